// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants, ALU control codes and the decoded
// control bundle shared by the MIPS decode stage and its control decoder.
package mips_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;

  // ALU control codes seen by execute
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_MUL = 4'b0011,
    ALU_DIV = 4'b0100,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_ctr_e;

  // Control bundle produced per instruction
  typedef struct packed {
    alu_ctr_e alu_ctr;
    logic     reg_wrt;
    logic     mem_read;
    logic     mem_wrt;
    logic     mem_reg;
    logic     alu_src;
    logic     branch;
    logic     jump;
    logic     illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'(0);

  // Instructions that read rt as a source operand (matters for load-use)
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: purely combinational instruction -> control bundle,
// register indices, extended immediate and jump target.
// Optional MULT/DIV decode is enabled by defining MIPS_DECODE_MULDIV_EN.
module mips_ctrl_decode
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-29:0] pc_hi,
  output ctrl_t           ctrl,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      wr_reg,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] jtarget,
  output logic            uses_rt,
  output logic            is_lw
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rd;
  logic       wr_sel_rd;
  logic       zero_ext;

  assign op    = inst[31:26];
  assign funct = inst[5:0];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];

  assign uses_rt = reads_rt(op);
  assign is_lw   = (op == OP_LW);

  // Opcode/funct table; anything unrecognised is flagged illegal with no side effects
  always_comb begin
    ctrl      = CTRL_NOP;
    wr_sel_rd = 1'b0;
    zero_ext  = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_wrt = 1'b1;
        wr_sel_rd    = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_ctr = ALU_ADD;
          FN_SUB:  ctrl.alu_ctr = ALU_SUB;
          FN_AND:  ctrl.alu_ctr = ALU_AND;
          FN_OR:   ctrl.alu_ctr = ALU_OR;
          FN_SLT:  ctrl.alu_ctr = ALU_SLT;
`ifdef MIPS_DECODE_MULDIV_EN
          FN_MULT: ctrl.alu_ctr = ALU_MUL;
          FN_DIV:  ctrl.alu_ctr = ALU_DIV;
`endif
          default: begin
            ctrl.reg_wrt = 1'b0;
            wr_sel_rd    = 1'b0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.alu_ctr  = ALU_ADD;
        ctrl.alu_src  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.mem_reg  = 1'b1;
        ctrl.reg_wrt  = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_ctr = ALU_ADD;
        ctrl.alu_src = 1'b1;
        ctrl.mem_wrt = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_ctr = ALU_SUB;
        ctrl.branch  = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_ctr = ALU_ADD;
        ctrl.alu_src = 1'b1;
        ctrl.reg_wrt = 1'b1;
      end
      OP_ORI: begin
        ctrl.alu_ctr = ALU_OR;
        ctrl.alu_src = 1'b1;
        ctrl.reg_wrt = 1'b1;
        zero_ext     = 1'b1;
      end
      OP_ANDI: begin
        ctrl.alu_ctr = ALU_AND;
        ctrl.alu_src = 1'b1;
        ctrl.reg_wrt = 1'b1;
        zero_ext     = 1'b1;
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

  // Destination is rd for R-type, rt otherwise, and 0 for anything that does not write
  assign wr_reg = !ctrl.reg_wrt ? 5'd0 : (wr_sel_rd ? rd : rt);

  assign imm = zero_ext ? {{(XLEN-16){1'b0}}, inst[15:0]}
                        : {{(XLEN-16){inst[15]}}, inst[15:0]};

  assign jtarget = {pc_hi, inst[25:0], 2'b00};

endmodule

// File: rtl/mips_decode_stage.sv
// mips_decode_stage: registered, valid/ready decode stage with load-use
// bubble insertion and synchronous flush. Decode table lives in
// mips_ctrl_decode; MULT/DIV support is enabled by MIPS_DECODE_MULDIV_EN.
module mips_decode_stage
  import mips_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ALU_CTR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ALU_CTR_W-1:0] out_alu_ctr,
  output logic                 out_reg_wrt,
  output logic                 out_mem_read,
  output logic                 out_mem_wrt,
  output logic                 out_mem_reg,
  output logic                 out_alu_src,
  output logic                 out_branch,
  output logic                 out_jump,
  output logic [4:0]           out_rs,
  output logic [4:0]           out_rt,
  output logic [4:0]           out_wr_reg,
  output logic [XLEN-1:0]      out_imm,
  output logic [XLEN-1:0]      out_jtarget,
  output logic                 out_illegal
);

  ctrl_t           dec_ctrl;
  logic [4:0]      dec_rs;
  logic [4:0]      dec_rt;
  logic [4:0]      dec_wr_reg;
  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_jtarget;
  logic            dec_uses_rt;
  logic            dec_is_lw;

  ctrl_t           ctrl_q;
  logic [4:0]      rs_q;
  logic [4:0]      rt_q;
  logic [4:0]      wr_reg_q;
  logic [XLEN-1:0] imm_q;
  logic [XLEN-1:0] jtarget_q;

  logic            lw_pend;
  logic [4:0]      lw_dst;
  logic            hazard;
  logic            accept;
  logic            unused_pc_low;

  // Only the PC region bits feed the jump target
  assign unused_pc_low = ^in_pc[27:0];

  mips_ctrl_decode #(
    .XLEN (XLEN)
  ) u_ctrl_decode (
    .inst    (in_inst),
    .pc_hi   (in_pc[XLEN-1:28]),
    .ctrl    (dec_ctrl),
    .rs      (dec_rs),
    .rt      (dec_rt),
    .wr_reg  (dec_wr_reg),
    .imm     (dec_imm),
    .jtarget (dec_jtarget),
    .uses_rt (dec_uses_rt),
    .is_lw   (dec_is_lw)
  );

  // A pending load blocks any incoming instruction that reads its destination
  assign hazard = lw_pend && in_valid &&
                  ((dec_rs == lw_dst) || (dec_uses_rt && (dec_rt == lw_dst)));

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // Output register: flush drops the bundle, accept replaces it, transfer empties it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ctrl_q    <= CTRL_NOP;
      rs_q      <= '0;
      rt_q      <= '0;
      wr_reg_q  <= '0;
      imm_q     <= '0;
      jtarget_q <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl_q    <= dec_ctrl;
      rs_q      <= dec_rs;
      rt_q      <= dec_rt;
      wr_reg_q  <= dec_wr_reg;
      imm_q     <= dec_imm;
      jtarget_q <= dec_jtarget;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Remember the destination of an issued LW until it leaves the stage
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      lw_pend <= 1'b0;
      lw_dst  <= '0;
    end else if (accept && dec_is_lw && (dec_rt != 5'd0)) begin
      lw_pend <= 1'b1;
      lw_dst  <= dec_rt;
    end else if (out_valid && out_ready) begin
      lw_pend <= 1'b0;
    end
  end

  assign out_alu_ctr  = ALU_CTR_W'(ctrl_q.alu_ctr);
  assign out_reg_wrt  = ctrl_q.reg_wrt;
  assign out_mem_read = ctrl_q.mem_read;
  assign out_mem_wrt  = ctrl_q.mem_wrt;
  assign out_mem_reg  = ctrl_q.mem_reg;
  assign out_alu_src  = ctrl_q.alu_src;
  assign out_branch   = ctrl_q.branch;
  assign out_jump     = ctrl_q.jump;
  assign out_illegal  = ctrl_q.illegal;
  assign out_rs       = rs_q;
  assign out_rt       = rt_q;
  assign out_wr_reg   = wr_reg_q;
  assign out_imm      = imm_q;
  assign out_jtarget  = jtarget_q;

endmodule
